// File: rtl/ghost_move_sched.sv
// rtl/ghost_move_sched.sv - two-ghost greedy move scheduler driven by a latency-RD_LAT proximity map RAM
module ghost_move_sched #(
  parameter int RD_LAT = 2,
  parameter int G1_X0  = 16,
  parameter int G1_Y0  = 13,
  parameter int G2_X0  = 23,
  parameter int G2_Y0  = 13
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       map_ready,
  input  logic [7:0] rd_data,
  output logic [5:0] rdaddr_x,
  output logic [4:0] rdaddr_y,
  output logic [5:0] ghost1_x,
  output logic [4:0] ghost1_y,
  output logic [5:0] ghost2_x,
  output logic [4:0] ghost2_y,
  output logic [5:0] prev_ghost1_x,
  output logic [4:0] prev_ghost1_y,
  output logic [5:0] prev_ghost2_x,
  output logic [4:0] prev_ghost2_y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_COMMIT,
    S_DONE
  } state_t;

  // Playfield is 40 columns by 30 rows; anything past these edges is a wall.
  localparam logic [5:0] X_MAX     = 6'd39;
  localparam logic [4:0] Y_MAX     = 5'd29;
  localparam bit         HAS_WAIT  = (RD_LAT > 1);
  localparam int         WAIT_CYC  = (RD_LAT > 1) ? (RD_LAT - 1) : 1;
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYC - 1);
  // Cell values at or above this code mean trail, ghost or wall.
  localparam logic [7:0] BLOCK_MIN = 8'hFD;

  state_t     state_q, state_d;
  logic       pending_q, pending_d;
  logic       ghost_sel_q, ghost_sel_d;
  logic [1:0] dir_q, dir_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [5:0] rd_x_q, rd_x_d;
  logic [4:0] rd_y_q, rd_y_d;
  logic [5:0] cand_x_q, cand_x_d;
  logic [4:0] cand_y_q, cand_y_d;
  logic       off_q, off_d;
  logic       best_valid_q, best_valid_d;
  logic [7:0] best_val_q, best_val_d;
  logic [5:0] best_x_q, best_x_d;
  logic [4:0] best_y_q, best_y_d;
  logic [5:0] g1_x_q, g1_x_d, g2_x_q, g2_x_d;
  logic [4:0] g1_y_q, g1_y_d, g2_y_q, g2_y_d;
  logic [5:0] p1_x_q, p1_x_d, p2_x_q, p2_x_d;
  logic [4:0] p1_y_q, p1_y_d, p2_y_q, p2_y_d;

  // Which ghost/direction the next ISSUE slot will probe.
  logic       nxt_ghost;
  logic [1:0] nxt_dir;
  // Neighbour of that ghost in that direction, plus whether it is off-grid.
  logic [5:0] src_x, nb_x;
  logic [4:0] src_y, nb_y;
  logic       nb_off;
  // Value seen in EVAL and whether it qualifies as a candidate.
  logic [7:0] eval_val;
  logic       eval_ok;

  // Select the ghost/direction for the upcoming probe from the current state.
  always_comb begin
    nxt_ghost = 1'b0;
    nxt_dir   = 2'd0;
    if (state_q == S_EVAL) begin
      nxt_ghost = ghost_sel_q;
      nxt_dir   = dir_q + 2'd1;
    end else if (state_q == S_COMMIT) begin
      nxt_ghost = 1'b1;
    end
  end

  // Neighbour address; an off-grid neighbour keeps the ghost's own cell so the read never wraps.
  always_comb begin
    src_x  = nxt_ghost ? g2_x_q : g1_x_q;
    src_y  = nxt_ghost ? g2_y_q : g1_y_q;
    nb_x   = src_x;
    nb_y   = src_y;
    nb_off = 1'b0;
    case (nxt_dir)
      2'd0: begin
        if (src_y == 5'd0) nb_off = 1'b1;
        else               nb_y   = src_y - 5'd1;
      end
      2'd1: begin
        if (src_x == 6'd0) nb_off = 1'b1;
        else               nb_x   = src_x - 6'd1;
      end
      2'd2: begin
        if (src_y >= Y_MAX) nb_off = 1'b1;
        else                nb_y   = src_y + 5'd1;
      end
      default: begin
        if (src_x >= X_MAX) nb_off = 1'b1;
        else                nb_x   = src_x + 6'd1;
      end
    endcase
  end

  // Candidate qualification; ghost2 may not land on ghost1's freshly committed cell.
  always_comb begin
    eval_val = off_q ? 8'hFF : rd_data;
    eval_ok  = (eval_val < BLOCK_MIN) &&
               !(ghost_sel_q && (cand_x_q == g1_x_q) && (cand_y_q == g1_y_q));
  end

  // Next-state and datapath updates for the step sequencer.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    ghost_sel_d  = ghost_sel_q;
    dir_d        = dir_q;
    wait_cnt_d   = wait_cnt_q;
    rd_x_d       = rd_x_q;
    rd_y_d       = rd_y_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    off_d        = off_q;
    best_valid_d = best_valid_q;
    best_val_d   = best_val_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    g1_x_d       = g1_x_q;
    g1_y_d       = g1_y_q;
    g2_x_d       = g2_x_q;
    g2_y_d       = g2_y_q;
    p1_x_d       = p1_x_q;
    p1_y_d       = p1_y_q;
    p2_x_d       = p2_x_q;
    p2_y_d       = p2_y_q;

    case (state_q)
      S_IDLE: begin
        if (map_ready && (tick || pending_q)) begin
          state_d   = S_ISSUE;
          pending_d = 1'b0;
        end else if (tick && !map_ready) begin
          pending_d = 1'b1;
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = HAS_WAIT ? S_WAIT : S_EVAL;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_EVAL;
        else                         wait_cnt_d = wait_cnt_q + 8'd1;
      end
      S_EVAL: begin
        if (eval_ok && (!best_valid_q || (eval_val < best_val_q))) begin
          best_valid_d = 1'b1;
          best_val_d   = eval_val;
          best_x_d     = cand_x_q;
          best_y_d     = cand_y_q;
        end
        if (dir_q == 2'd3) state_d = S_COMMIT;
        else               state_d = S_ISSUE;
      end
      S_COMMIT: begin
        if (!ghost_sel_q) begin
          p1_x_d = g1_x_q;
          p1_y_d = g1_y_q;
          if (best_valid_q) begin
            g1_x_d = best_x_q;
            g1_y_d = best_y_q;
          end
          state_d = S_ISSUE;
        end else begin
          p2_x_d = g2_x_q;
          p2_y_d = g2_y_q;
          if (best_valid_q) begin
            g2_x_d = best_x_q;
            g2_y_d = best_y_q;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Every entry into ISSUE latches the probe address; direction 0 starts a fresh search.
    if (state_d == S_ISSUE) begin
      ghost_sel_d = nxt_ghost;
      dir_d       = nxt_dir;
      rd_x_d      = nb_x;
      rd_y_d      = nb_y;
      cand_x_d    = nb_x;
      cand_y_d    = nb_y;
      off_d       = nb_off;
      if (nxt_dir == 2'd0) best_valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      ghost_sel_q  <= 1'b0;
      dir_q        <= 2'd0;
      wait_cnt_q   <= '0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      off_q        <= 1'b0;
      best_valid_q <= 1'b0;
      best_val_q   <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      g1_x_q       <= 6'(G1_X0);
      g1_y_q       <= 5'(G1_Y0);
      g2_x_q       <= 6'(G2_X0);
      g2_y_q       <= 5'(G2_Y0);
      p1_x_q       <= 6'(G1_X0);
      p1_y_q       <= 5'(G1_Y0);
      p2_x_q       <= 6'(G2_X0);
      p2_y_q       <= 5'(G2_Y0);
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      ghost_sel_q  <= ghost_sel_d;
      dir_q        <= dir_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_x_q       <= rd_x_d;
      rd_y_q       <= rd_y_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      off_q        <= off_d;
      best_valid_q <= best_valid_d;
      best_val_q   <= best_val_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      g1_x_q       <= g1_x_d;
      g1_y_q       <= g1_y_d;
      g2_x_q       <= g2_x_d;
      g2_y_q       <= g2_y_d;
      p1_x_q       <= p1_x_d;
      p1_y_q       <= p1_y_d;
      p2_x_q       <= p2_x_d;
      p2_y_q       <= p2_y_d;
    end
  end

  assign rdaddr_x      = rd_x_q;
  assign rdaddr_y      = rd_y_q;
  assign ghost1_x      = g1_x_q;
  assign ghost1_y      = g1_y_q;
  assign ghost2_x      = g2_x_q;
  assign ghost2_y      = g2_y_q;
  assign prev_ghost1_x = p1_x_q;
  assign prev_ghost1_y = p1_y_q;
  assign prev_ghost2_x = p2_x_q;
  assign prev_ghost2_y = p2_y_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule
